// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared types for the Tomasulo back end.
//   reg_t / tag_t / robid_t / word_t : architectural register, producer tag,
//                                      reorder-buffer id and data word.
//   cdb_t          : common data bus broadcast {vld, wa, tag, robid, wdata}.
//   issue_t        : operation handed to an execution unit {wa, tag, robid, a, b}.
//   mpy_rs_opr_t   : reservation-station source operand {rdy, tag, data}.
//   mpy_rs_entry_t : multiplier reservation-station entry {wa, tag, robid, opr[1:0]}.
// Helpers: opr_wake (operand is waiting on the tag the CDB carries now) and
// opr_capture (operand after snooping the CDB for one cycle).
package tomasulo_pkg;

    localparam int REG_W   = 5;
    localparam int TAG_W   = 4;
    localparam int ROBID_W = 4;
    localparam int WORD_W  = 32;

    typedef logic [REG_W-1:0]   reg_t;
    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [ROBID_W-1:0] robid_t;
    typedef logic [WORD_W-1:0]  word_t;

    typedef struct packed {
        logic   vld;
        reg_t   wa;
        tag_t   tag;
        robid_t robid;
        word_t  wdata;
    } cdb_t;

    typedef struct packed {
        reg_t   wa;
        tag_t   tag;
        robid_t robid;
        word_t  a;
        word_t  b;
    } issue_t;

    typedef struct packed {
        logic  rdy;
        tag_t  tag;
        word_t data;
    } mpy_rs_opr_t;

    typedef struct packed {
        reg_t              wa;
        tag_t              tag;
        robid_t            robid;
        mpy_rs_opr_t [1:0] opr;
    } mpy_rs_entry_t;

    function automatic logic opr_wake(input mpy_rs_opr_t opr, input cdb_t cdb);
        return !opr.rdy && cdb.vld && (opr.tag == cdb.tag);
    endfunction

    function automatic mpy_rs_opr_t opr_capture(input mpy_rs_opr_t opr, input cdb_t cdb);
        mpy_rs_opr_t res;
        if (opr_wake(opr, cdb)) begin
            res = '{rdy: 1'b1, tag: opr.tag, data: cdb.wdata};
        end else begin
            res = opr;
        end
        return res;
    endfunction

endpackage

// File: rtl/tomasulo_age_matrix.sv
// tomasulo_age_matrix: relative-age tracker for an N-slot reservation station.
//   clk, rst (async, active-high), clr (sync clear of all relations)
//   alloc   [N] one-hot: slot written this cycle, becomes youngest
//   dealloc [N] one-hot: slot released this cycle
//   req     [N] candidate slots
//   gnt     [N] one-hot oldest requesting slot (zero when req is zero)
// older_r[i][j] = 1 means slot i was allocated before slot j. Allocating a slot
// rewrites its whole row and column, so the relation between any two live
// slots is always exact regardless of stale bits left behind by dead slots.
module tomasulo_age_matrix #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [N-1:0] alloc,
    input  logic [N-1:0] dealloc,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    logic [N-1:0] older_r [N];
    logic [N-1:0] blocked_s;

    // Age relation update on allocate / release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) older_r[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < N; i++) older_r[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (i == j) begin
                        older_r[i][j] <= 1'b0;
                    end else if (alloc[i]) begin
                        older_r[i][j] <= 1'b0;
                    end else if (dealloc[i] || dealloc[j]) begin
                        older_r[i][j] <= 1'b0;
                    end else if (alloc[j]) begin
                        older_r[i][j] <= 1'b1;
                    end else begin
                        older_r[i][j] <= older_r[i][j];
                    end
                end
            end
        end
    end

    // A requester is blocked when any other requester is older than it.
    always_comb begin
        blocked_s = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                blocked_s[i] = blocked_s[i] | (req[j] & older_r[j][i] & (j != i));
            end
        end
        gnt = req & ~blocked_s;
    end

endmodule

// File: rtl/tomasulo_mpy_sched.sv
// tomasulo_mpy_sched: reservation station + issue scheduler for the multiplier.
//   clk, rst (async, active-high), flush (sync kill of all held entries)
//   disp_vld / disp / disp_rdy : dispatch handshake; disp_rdy = a slot is free
//   cdb                        : result broadcast snooped for waiting operands
//   iss_vld / iss              : oldest ready entry issued to the multiplier
//   occ_r                      : registered count of valid entries
// Parameters: N_ENTRIES (depth, >=2), II_N (minimum cycles between issues).
// Optional macro TOMASULO_MPY_SCHED_BYPASS_EN: an entry whose last missing
// operand is on the CDB this cycle may issue in the same cycle, taking the
// operand straight from cdb.wdata. Without it, readiness uses captured state.
module tomasulo_mpy_sched
    import tomasulo_pkg::*;
#(
    parameter int N_ENTRIES = 4,
    parameter int II_N      = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           disp_vld,
    input  mpy_rs_entry_t                  disp,
    output logic                           disp_rdy,
    input  cdb_t                           cdb,
    output logic                           iss_vld,
    output issue_t                         iss,
    output logic [$clog2(N_ENTRIES+1)-1:0] occ_r
);

    localparam int OCC_W = $clog2(N_ENTRIES + 1);
    localparam int THR_W = (II_N > 1) ? $clog2(II_N) : 1;
    localparam logic [THR_W-1:0] THR_LOAD = THR_W'(II_N - 1);

    logic [N_ENTRIES-1:0] vld_r;
    mpy_rs_entry_t        ent_r [N_ENTRIES];
    logic [THR_W-1:0]     thr_r;

    logic [N_ENTRIES-1:0] free_s;
    logic [N_ENTRIES-1:0] alloc_s;
    logic [N_ENTRIES-1:0] req_s;
    logic [N_ENTRIES-1:0] gnt_s;
    logic [N_ENTRIES-1:0] dealloc_s;
    logic                 disp_fire_s;
    mpy_rs_entry_t        disp_cap_s;
    mpy_rs_entry_t        sel_s;
    logic                 cdb_unused_s;

    assign cdb_unused_s = ^{cdb.wa, cdb.robid};

    // Lowest-index free slot; the two's-complement trick isolates the lowest set bit.
    assign free_s      = ~vld_r;
    assign disp_rdy    = |free_s;
    assign disp_fire_s = disp_vld & disp_rdy & ~flush;
    assign alloc_s     = (free_s & (~free_s + N_ENTRIES'(1))) & {N_ENTRIES{disp_fire_s}};

    // Incoming operation with its operands snooped against this cycle's CDB.
    always_comb begin
        disp_cap_s        = disp;
        disp_cap_s.opr[0] = opr_capture(disp.opr[0], cdb);
        disp_cap_s.opr[1] = opr_capture(disp.opr[1], cdb);
    end

    // Per-entry readiness, optionally counting an operand arriving on the CDB now.
    always_comb begin
        req_s = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
`ifdef TOMASULO_MPY_SCHED_BYPASS_EN
            req_s[i] = vld_r[i]
                     & (ent_r[i].opr[0].rdy | opr_wake(ent_r[i].opr[0], cdb))
                     & (ent_r[i].opr[1].rdy | opr_wake(ent_r[i].opr[1], cdb));
`else
            req_s[i] = vld_r[i] & ent_r[i].opr[0].rdy & ent_r[i].opr[1].rdy;
`endif
        end
    end

    tomasulo_age_matrix #(
        .N (N_ENTRIES)
    ) u_age (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .alloc   (alloc_s),
        .dealloc (dealloc_s),
        .req     (req_s),
        .gnt     (gnt_s)
    );

    assign iss_vld   = (|req_s) & (thr_r == '0) & ~flush;
    assign dealloc_s = gnt_s & {N_ENTRIES{iss_vld}};

    // AND-OR mux of the granted entry onto the issue port.
    always_comb begin
        sel_s = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            sel_s = mpy_rs_entry_t'(sel_s | (ent_r[i] & {$bits(mpy_rs_entry_t){gnt_s[i]}}));
        end
        iss.wa    = sel_s.wa;
        iss.tag   = sel_s.tag;
        iss.robid = sel_s.robid;
`ifdef TOMASULO_MPY_SCHED_BYPASS_EN
        iss.a     = opr_capture(sel_s.opr[0], cdb).data;
        iss.b     = opr_capture(sel_s.opr[1], cdb).data;
`else
        iss.a     = sel_s.opr[0].data;
        iss.b     = sel_s.opr[1].data;
`endif
    end

    // Entry storage: allocate, release on issue, snoop CDB for waiting operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_r <= '0;
            for (int i = 0; i < N_ENTRIES; i++) ent_r[i] <= '0;
        end else if (flush) begin
            vld_r <= '0;
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (alloc_s[i]) begin
                    vld_r[i] <= 1'b1;
                    ent_r[i] <= disp_cap_s;
                end else begin
                    vld_r[i]        <= vld_r[i] & ~dealloc_s[i];
                    ent_r[i].opr[0] <= opr_capture(ent_r[i].opr[0], cdb);
                    ent_r[i].opr[1] <= opr_capture(ent_r[i].opr[1], cdb);
                end
            end
        end
    end

    // Issue-interval throttle: reload on issue, count down to zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_r <= '0;
        end else if (flush) begin
            thr_r <= '0;
        end else if (iss_vld) begin
            thr_r <= THR_LOAD;
        end else if (thr_r != '0) begin
            thr_r <= thr_r - THR_W'(1);
        end else begin
            thr_r <= thr_r;
        end
    end

    // Occupancy count; a simultaneous dispatch and issue cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_r <= '0;
        end else if (flush) begin
            occ_r <= '0;
        end else begin
            case ({disp_fire_s, iss_vld})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

endmodule
